cfg_sequencer: RTL and testbench

Host-side initiator for the accelerator's 16-bit configuration port. It reads per-layer descriptors, four 16-bit words per layer, from a synchronous descriptor RAM. For each layer it issues the four config writes (addresses 0..3), pulses start, and waits for finish before moving to the next layer. It replaces bench-driven config/start stimulus and sits between the descriptor store and the core's `i_cfg`/`i_cfg_addr`/`i_cfg_wr_en`/`i_start`/`o_finish` pins.

---
 rtl/cfg_sequencer.sv | 143 ++++++++++++++
 tb/tb_cfg_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_sequencer.sv
// Purpose: walks per-layer descriptors in RAM and drives the core's config writes, start and finish handshake.
// Latency: reads on cycles 1-4 after go, writes on 3-6, start on 7, WAIT from 8; 8 cycles of overhead per layer.
// Backpressure: none on the config port; the sequencer stalls only in WAIT until the core raises finish.
module cfg_sequencer #(
    parameter int AW = 10,
    parameter int LW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_go,
    input  logic [LW-1:0] i_num_layers,
    input  logic [AW-1:0] i_desc_base,
    output logic          o_desc_rd_en,
    output logic [AW-1:0] o_desc_addr,
    input  logic [15:0]   i_desc_data,
    output logic [15:0]   o_cfg,
    output logic [1:0]    o_cfg_addr,
    output logic          o_cfg_wr_en,
    output logic          o_start,
    input  logic          i_finish,
    output logic          o_busy,
    output logic          o_done,
    output logic [LW-1:0] o_layer_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [LW-1:0] num_layers_q;
    logic [AW-1:0] desc_base_q;
    logic [2:0]    rd_cnt;      // reads issued so far for the current layer
    logic [1:0]    wr_k;        // config index of the next returning word
    logic          rd_pend;     // RAM data is valid this cycle

    logic [LW-1:0] nxt_layer;
    logic [AW-1:0] nxt_addr;
    logic          last_layer;

    // Next-layer index, its descriptor address (wraps modulo 2^AW) and end-of-program detect
    assign nxt_layer  = o_layer_idx + 1'b1;
    assign nxt_addr   = desc_base_q + AW'({nxt_layer, 2'b00});
    assign last_layer = ({1'b0, o_layer_idx} + {{LW{1'b0}}, 1'b1}) == {1'b0, num_layers_q};

    // Sequencer FSM with all outputs registered
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= S_IDLE;
            num_layers_q <= '0;
            desc_base_q  <= '0;
            rd_cnt       <= '0;
            wr_k         <= '0;
            rd_pend      <= 1'b0;
            o_desc_rd_en <= 1'b0;
            o_desc_addr  <= '0;
            o_cfg        <= '0;
            o_cfg_addr   <= '0;
            o_cfg_wr_en  <= 1'b0;
            o_start      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_layer_idx  <= '0;
        end else begin
            o_start <= 1'b0;
            o_done  <= 1'b0;
            rd_pend <= o_desc_rd_en;
            case (state)
                S_IDLE: begin
                    o_desc_rd_en <= 1'b0;
                    o_cfg_wr_en  <= 1'b0;
                    if (i_go) begin
                        num_layers_q <= i_num_layers;
                        desc_base_q  <= i_desc_base;
                        o_layer_idx  <= '0;
                        wr_k         <= '0;
                        if (i_num_layers == '0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state        <= S_FETCH;
                            o_busy       <= 1'b1;
                            o_desc_rd_en <= 1'b1;
                            o_desc_addr  <= i_desc_base;
                            rd_cnt       <= 3'd1;
                        end
                    end
                end
                S_FETCH: begin
                    // Issue the remaining reads back to back
                    if (rd_cnt != 3'd4) begin
                        o_desc_addr  <= o_desc_addr + 1'b1;
                        rd_cnt       <= rd_cnt + 3'd1;
                        o_desc_rd_en <= 1'b1;
                    end else begin
                        o_desc_rd_en <= 1'b0;
                    end
                    // Forward each returning word as a config write
                    o_cfg_wr_en <= rd_pend;
                    if (rd_pend) begin
                        o_cfg      <= i_desc_data;
                        o_cfg_addr <= wr_k;
                        wr_k       <= wr_k + 2'd1;
                    end
                    if (o_cfg_wr_en && (o_cfg_addr == 2'd3)) begin
                        state   <= S_START;
                        o_start <= 1'b1;
                    end
                end
                S_START: begin
                    o_cfg_wr_en <= 1'b0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_finish) begin
                        if (last_layer) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            state        <= S_FETCH;
                            o_layer_idx  <= nxt_layer;
                            o_desc_rd_en <= 1'b1;
                            o_desc_addr  <= nxt_addr;
                            rd_cnt       <= 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_sequencer.sv
// Purpose: randomized scoreboard bench for cfg_sequencer against a timeline model of each program.
// Latency: expected events carry absolute cycle numbers derived from go and finish times.
// Backpressure: finish timing is chosen by the bench; the monitor pops one expectation per DUT strobe.
module tb_cfg_sequencer;

    logic        i_clk;
    logic        i_rst;
    logic        i_go;
    logic [7:0]  i_num_layers;
    logic [9:0]  i_desc_base;
    logic        o_desc_rd_en;
    logic [9:0]  o_desc_addr;
    logic [15:0] ram_q;
    logic [15:0] o_cfg;
    logic [1:0]  o_cfg_addr;
    logic        o_cfg_wr_en;
    logic        o_start;
    logic        i_finish;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_layer_idx;

    cfg_sequencer #(.AW(10), .LW(8)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_go         (i_go),
        .i_num_layers (i_num_layers),
        .i_desc_base  (i_desc_base),
        .o_desc_rd_en (o_desc_rd_en),
        .o_desc_addr  (o_desc_addr),
        .i_desc_data  (ram_q),
        .o_cfg        (o_cfg),
        .o_cfg_addr   (o_cfg_addr),
        .o_cfg_wr_en  (o_cfg_wr_en),
        .o_start      (o_start),
        .i_finish     (i_finish),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_layer_idx  (o_layer_idx)
    );

    localparam int K_WR = 0;
    localparam int K_ST = 1;
    localparam int K_DN = 2;

    typedef struct {
        int kind;
        int cyc;
        int addr;
        int data;
        int layer;
    } ev_t;

    typedef struct {
        int cyc;
        int addr;
    } rd_t;

    ev_t         ev_q[$];
    rd_t         rd_q[$];
    logic [15:0] mem [0:1023];
    int          cyc;
    int          total;
    int          bad;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Cycle counter: value during a cycle is the cycle number
    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Synchronous descriptor RAM
    always @(posedge i_clk) if (o_desc_rd_en) ram_q <= mem[o_desc_addr];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_cfg"},       int'(o_cfg), 0);
        chk({tag, "_cfg_addr"},  int'(o_cfg_addr), 0);
        chk({tag, "_wr_en"},     int'(o_cfg_wr_en), 0);
        chk({tag, "_start"},     int'(o_start), 0);
        chk({tag, "_rd_en"},     int'(o_desc_rd_en), 0);
        chk({tag, "_desc_addr"}, int'(o_desc_addr), 0);
        chk({tag, "_busy"},      int'(o_busy), 0);
        chk({tag, "_done"},      int'(o_done), 0);
        chk({tag, "_layer"},     int'(o_layer_idx), 0);
    endtask

    // Monitor: every strobe consumes the oldest matching expectation
    always @(negedge i_clk) begin
        rd_t r;
        ev_t e;
        if (i_rst) begin
            if (o_desc_rd_en) begin
                if (rd_q.size() == 0) chk("rd_unexpected", int'(o_desc_rd_en), 0);
                else begin
                    r = rd_q.pop_front();
                    chk("rd_cycle", cyc, r.cyc);
                    chk("rd_addr", int'(o_desc_addr), r.addr);
                end
            end
            if (o_cfg_wr_en || o_start || o_done) begin
                if (ev_q.size() == 0) chk("ev_unexpected", int'({o_cfg_wr_en, o_start, o_done}), 0);
                else begin
                    e = ev_q.pop_front();
                    chk("ev_kind", o_cfg_wr_en ? K_WR : (o_start ? K_ST : K_DN), e.kind);
                    chk("ev_cycle", cyc, e.cyc);
                    if (e.kind == K_WR) begin
                        chk("wr_addr", int'(o_cfg_addr), e.addr);
                        chk("wr_data", int'(o_cfg), e.data);
                    end
                    if (e.kind != K_DN) chk("layer_idx", int'(o_layer_idx), e.layer);
                end
            end
        end
    end

    // One program: build the expected timeline, then drive go/finish cycle by cycle
    task automatic run_prog(input int base, input int n, input int dly, input bit spur, input int abort_off);
        int c0;
        int s;
        int d;
        int done_c;
        int fs[$];
        int ss[$];
        ev_t e;
        rd_t r;
        bit lvl;
        @(negedge i_clk);
        #2;
        c0 = cyc;
        s  = c0;
        for (int l = 0; l < n; l++) begin
            ss.push_back(s);
            for (int k = 0; k < 4; k++) begin
                r.cyc  = s + 1 + k;
                r.addr = (base + 4 * l + k) % 1024;
                rd_q.push_back(r);
                e.kind = K_WR; e.cyc = s + 3 + k; e.addr = k;
                e.data = int'(mem[r.addr]); e.layer = l;
                ev_q.push_back(e);
            end
            e.kind = K_ST; e.cyc = s + 7; e.addr = 0; e.data = 0; e.layer = l;
            ev_q.push_back(e);
            d = (dly >= 0) ? dly : int'($urandom_range(0, 5));
            s = s + 8 + d;
            fs.push_back(s);
        end
        done_c = (n == 0) ? c0 + 1 : s + 1;
        e.kind = K_DN; e.cyc = done_c; e.addr = 0; e.data = 0; e.layer = 0;
        ev_q.push_back(e);
        i_num_layers = 8'(n);
        i_desc_base  = 10'(base);
        for (int c = c0; c <= done_c + 2; c++) begin
            if (abort_off >= 0 && c == c0 + abort_off) begin
                i_rst = 1'b0;
                #1;
                chk_rst("mid_rst");
                rd_q.delete();
                ev_q.delete();
                i_go     = 1'b0;
                i_finish = 1'b0;
                repeat (2) @(negedge i_clk);
                #2;
                chk_rst("held_rst");
                i_rst = 1'b1;
                return;
            end
            i_go = (c == c0) || (spur && (c == c0 + 2 || c == c0 + 9));
            lvl = 1'b0;
            for (int l = 0; l < n; l++) begin
                if (c == fs[l]) lvl = 1'b1;
                if (spur && c >= ss[l] + 1 && c <= ss[l] + 7) lvl = 1'b1;
            end
            i_finish = lvl;
            chk("busy", int'(o_busy), int'(c > c0 && c < done_c));
            @(negedge i_clk);
            #2;
        end
        i_go     = 1'b0;
        i_finish = 1'b0;
        chk("ev_left", ev_q.size(), 0);
        chk("rd_left", rd_q.size(), 0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        i_rst        = 1'b0;
        i_go         = 1'b0;
        i_finish     = 1'b0;
        i_num_layers = '0;
        i_desc_base  = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hCE00;
        mem[1] = 16'h0404;
        mem[2] = 16'h0003;
        mem[3] = 16'd200;
        repeat (3) @(negedge i_clk);
        #2;
        chk_rst("por");
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);

        // Single layer, finish ten cycles after start
        run_prog(0, 1, 9, 1'b0, -1);
        // Three layers with distinct random descriptors
        run_prog(int'($urandom_range(0, 1023)), 3, -1, 1'b0, -1);
        // Empty program
        run_prog(17, 0, 0, 1'b0, -1);
        // Descriptor address wrap
        run_prog(10'h3FE, 1, 2, 1'b0, -1);
        // Spurious finish and go while busy
        run_prog(0, 1, 9, 1'b1, -1);
        run_prog(40, 2, -1, 1'b1, -1);
        // Reset during the k=2 write, then during WAIT
        run_prog(100, 2, 4, 1'b0, 5);
        run_prog(200, 1, 10, 1'b0, 12);
        // Fresh run after reset, then a few random programs
        run_prog(300, 2, -1, 1'b0, -1);
        for (int t = 0; t < 4; t++) begin
            run_prog(int'($urandom_range(0, 1023)), int'($urandom_range(1, 4)), -1, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
